// File: rtl/gen_sine_voice.sv
// gen_sine_voice: single-voice MIDI sine generator that computes its samples on the shared dual-lane DSP ALU.
// Optional macro GEN_SINE_REFINE_EN adds a refinement pass that turns the parabola into a near-exact sine.

`ifndef MIDI_CMD_SIZE
`define MIDI_CMD_SIZE 4
`endif
`ifndef MIDI_CMD_NOTE_ON
`define MIDI_CMD_NOTE_ON 4'h9
`endif
`ifndef MIDI_CMD_NOTE_OFF
`define MIDI_CMD_NOTE_OFF 4'h8
`endif

module gen_sine_voice #(
    parameter int MIDI_CH     = 0,
    parameter int SAMPLE_RATE = 48000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      midi_rdy,
    input  logic [`MIDI_CMD_SIZE-1:0] midi_cmd,
    input  logic [3:0]                midi_ch_sysn,
    input  logic [6:0]                midi_data0,
    input  logic [6:0]                midi_data1,
    input  logic                      smp_trig,
    output logic                      smp_out_rdy,
    output logic signed [17:0]        smp_out_l,
    output logic signed [17:0]        smp_out_r,
    output logic                      alu_cycle,
    output logic                      alu_strobe,
    input  logic                      alu_ack,
    input  logic                      alu_stall,
    output logic [8:0]                alu_op,
    output logic signed [17:0]        alu_al,
    output logic signed [17:0]        alu_bl,
    output logic signed [47:0]        alu_cl,
    input  logic signed [47:0]        alu_pl,
    output logic signed [17:0]        alu_ar,
    output logic signed [17:0]        alu_br,
    output logic signed [47:0]        alu_cr,
    input  logic signed [47:0]        alu_pr
);

    localparam logic [8:0] OP_MUL     = 9'h001;
    localparam logic [8:0] OP_MUL_ADD = 9'h00D;

    // Phase increment for note 120+k; lower octaves are obtained by right shifts.
    function automatic logic [31:0] inc_calc(input int k);
        real freq;
        real scaled;
        freq   = 440.0 * (2.0 ** ((51.0 + real'(k)) / 12.0));
        scaled = freq * 4294967296.0 / real'(SAMPLE_RATE);
        return 32'(longint'($floor(scaled + 0.5)));
    endfunction

    localparam logic [31:0] INC_TAB [12] = '{
        inc_calc(0), inc_calc(1), inc_calc(2),  inc_calc(3),
        inc_calc(4), inc_calc(5), inc_calc(6),  inc_calc(7),
        inc_calc(8), inc_calc(9), inc_calc(10), inc_calc(11)
    };

    function automatic logic signed [17:0] sat18(input logic signed [47:0] v);
        if (v > 48'sd131071)
            return 18'sd131071;
        if (v < -48'sd131071)
            return -18'sd131071;
        return v[17:0];
    endfunction

    typedef enum logic [2:0] {
        IDLE,
        MUL1_REQ,
        MUL1_WAIT,
`ifdef GEN_SINE_REFINE_EN
        REF_REQ,
        REF_WAIT,
`endif
        MUL2_REQ,
        MUL2_WAIT,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [31:0]        phase;
    logic [31:0]        inc;
    logic [6:0]         vel;
    logic [6:0]         note;
    logic [6:0]         vel_s;
    logic signed [17:0] x_reg;
    logic signed [17:0] y_l;
    logic signed [17:0] y_r;
    logic signed [17:0] res_l;
    logic signed [17:0] res_r;

    logic        midi_hit;
    logic        is_note_on;
    logic        is_note_off;
    logic [3:0]  semi;
    logic [3:0]  octave;
    logic [31:0] note_inc;

    assign midi_hit    = midi_rdy && (midi_ch_sysn == 4'(MIDI_CH));
    assign is_note_on  = (midi_cmd == `MIDI_CMD_NOTE_ON);
    assign is_note_off = (midi_cmd == `MIDI_CMD_NOTE_OFF);
    assign semi        = 4'(midi_data0 % 7'd12);
    assign octave      = 4'(midi_data0 / 7'd12);
    assign note_inc    = INC_TAB[semi] >> (4'd10 - octave);

    // Voice parameters follow MIDI; phase advances once per finished sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            note  <= '0;
            vel   <= '0;
            inc   <= '0;
            phase <= '0;
        end else begin
            if (midi_hit && is_note_on && midi_data1 != 7'd0) begin
                note <= midi_data0;
                vel  <= midi_data1;
                inc  <= note_inc;
            end else if (midi_hit && (is_note_on || (is_note_off && midi_data0 == note))) begin
                vel <= '0;
            end
            if (state == DONE)
                phase <= phase + inc;
        end
    end

    // Parabola factor (1 - |x|), clamped because +1.0 is not representable in Q0.17.
    logic signed [18:0] x_ext;
    logic signed [18:0] x_abs;
    logic signed [18:0] b_full;
    logic signed [17:0] mul1_b;
    logic signed [17:0] mul2_b;

    assign x_ext  = {x_reg[17], x_reg};
    assign x_abs  = x_reg[17] ? -x_ext : x_ext;
    assign b_full = 19'sd131072 - x_abs;
    assign mul1_b = (b_full > 19'sd131071) ? 18'sd131071 : b_full[17:0];
    assign mul2_b = {1'b0, vel_s, 10'b0};

`ifdef GEN_SINE_REFINE_EN
    logic signed [18:0] y_ext;
    logic signed [18:0] y_abs;
    logic signed [18:0] y_dev;
    logic signed [37:0] ref_prod;
    logic signed [17:0] ref_b;

    assign y_ext    = {y_l[17], y_l};
    assign y_abs    = y_l[17] ? -y_ext : y_ext;
    assign y_dev    = y_abs - 19'sd131071;
    assign ref_prod = 38'(y_dev) * 38'sd29491;
    assign ref_b    = 18'(ref_prod >>> 17);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        alu_cycle  = 1'b0;
        alu_strobe = 1'b0;
        alu_op     = '0;
        alu_al     = '0;
        alu_bl     = '0;
        alu_cl     = '0;
        alu_ar     = '0;
        alu_br     = '0;
        alu_cr     = '0;
        case (state)
            IDLE: begin
                if (smp_trig)
                    next_state = MUL1_REQ;
            end
            MUL1_REQ: begin
                alu_cycle  = 1'b1;
                alu_strobe = 1'b1;
                alu_op     = OP_MUL;
                alu_al     = x_reg;
                alu_bl     = mul1_b;
                alu_ar     = x_reg;
                alu_br     = mul1_b;
                if (!alu_stall)
                    next_state = MUL1_WAIT;
            end
            MUL1_WAIT: begin
                alu_cycle = 1'b1;
                if (alu_ack)
`ifdef GEN_SINE_REFINE_EN
                    next_state = REF_REQ;
`else
                    next_state = MUL2_REQ;
`endif
            end
`ifdef GEN_SINE_REFINE_EN
            REF_REQ: begin
                alu_cycle  = 1'b1;
                alu_strobe = 1'b1;
                alu_op     = OP_MUL_ADD;
                alu_al     = y_l;
                alu_bl     = ref_b;
                alu_cl     = 48'(y_l) <<< 17;
                alu_ar     = y_r;
                alu_br     = ref_b;
                alu_cr     = 48'(y_r) <<< 17;
                if (!alu_stall)
                    next_state = REF_WAIT;
            end
            REF_WAIT: begin
                alu_cycle = 1'b1;
                if (alu_ack)
                    next_state = MUL2_REQ;
            end
`endif
            MUL2_REQ: begin
                alu_cycle  = 1'b1;
                alu_strobe = 1'b1;
                alu_op     = OP_MUL;
                alu_al     = y_l;
                alu_bl     = mul2_b;
                alu_ar     = y_r;
                alu_br     = mul2_b;
                if (!alu_stall)
                    next_state = MUL2_WAIT;
            end
            MUL2_WAIT: begin
                alu_cycle = 1'b1;
                if (alu_ack)
                    next_state = DONE;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Velocity is frozen on entry to the scaling multiply so MIDI traffic only affects later samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_reg       <= '0;
            y_l         <= '0;
            y_r         <= '0;
            vel_s       <= '0;
            res_l       <= '0;
            res_r       <= '0;
            smp_out_l   <= '0;
            smp_out_r   <= '0;
            smp_out_rdy <= 1'b0;
        end else begin
            smp_out_rdy <= (state == DONE);
            case (state)
                IDLE: begin
                    if (smp_trig)
                        x_reg <= phase[31:14];
                end
                MUL1_WAIT: begin
                    if (alu_ack) begin
                        y_l <= sat18(alu_pl >>> 15);
                        y_r <= sat18(alu_pr >>> 15);
`ifndef GEN_SINE_REFINE_EN
                        vel_s <= vel;
`endif
                    end
                end
`ifdef GEN_SINE_REFINE_EN
                REF_WAIT: begin
                    if (alu_ack) begin
                        y_l   <= sat18(alu_pl >>> 17);
                        y_r   <= sat18(alu_pr >>> 17);
                        vel_s <= vel;
                    end
                end
`endif
                MUL2_WAIT: begin
                    if (alu_ack) begin
                        res_l <= 18'(alu_pl >>> 17);
                        res_r <= 18'(alu_pr >>> 17);
                    end
                end
                DONE: begin
                    smp_out_l <= res_l;
                    smp_out_r <= res_r;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gen_sine_voice.sv
// tb_gen_sine_voice: table-driven MIDI vectors with a sample scoreboard; the bench also plays the ALU.
// Build with GEN_SINE_REFINE_EN defined to cover the refinement variant.

`ifndef MIDI_CMD_SIZE
`define MIDI_CMD_SIZE 4
`endif
`ifndef MIDI_CMD_NOTE_ON
`define MIDI_CMD_NOTE_ON 4'h9
`endif
`ifndef MIDI_CMD_NOTE_OFF
`define MIDI_CMD_NOTE_OFF 4'h8
`endif

module tb_gen_sine_voice;

`ifdef GEN_SINE_REFINE_EN
    localparam int OPS_PER_SAMPLE = 3;
`else
    localparam int OPS_PER_SAMPLE = 2;
`endif

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      midi_rdy;
    logic [`MIDI_CMD_SIZE-1:0] midi_cmd;
    logic [3:0]                midi_ch_sysn;
    logic [6:0]                midi_data0;
    logic [6:0]                midi_data1;
    logic                      smp_trig;
    logic                      smp_out_rdy;
    logic signed [17:0]        smp_out_l;
    logic signed [17:0]        smp_out_r;
    logic                      alu_cycle;
    logic                      alu_strobe;
    logic                      alu_ack = 1'b0;
    logic                      alu_stall = 1'b0;
    logic [8:0]                alu_op;
    logic signed [17:0]        alu_al;
    logic signed [17:0]        alu_bl;
    logic signed [47:0]        alu_cl;
    logic signed [47:0]        alu_pl = '0;
    logic signed [17:0]        alu_ar;
    logic signed [17:0]        alu_br;
    logic signed [47:0]        alu_cr;
    logic signed [47:0]        alu_pr = '0;

    gen_sine_voice #(.MIDI_CH(0), .SAMPLE_RATE(48000)) dut (
        .clk(clk), .reset(reset),
        .midi_rdy(midi_rdy), .midi_cmd(midi_cmd), .midi_ch_sysn(midi_ch_sysn),
        .midi_data0(midi_data0), .midi_data1(midi_data1),
        .smp_trig(smp_trig), .smp_out_rdy(smp_out_rdy),
        .smp_out_l(smp_out_l), .smp_out_r(smp_out_r),
        .alu_cycle(alu_cycle), .alu_strobe(alu_strobe), .alu_ack(alu_ack), .alu_stall(alu_stall),
        .alu_op(alu_op), .alu_al(alu_al), .alu_bl(alu_bl), .alu_cl(alu_cl), .alu_pl(alu_pl),
        .alu_ar(alu_ar), .alu_br(alu_br), .alu_cr(alu_cr), .alu_pr(alu_pr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [`MIDI_CMD_SIZE-1:0] cmd;
        logic [3:0]                ch;
        logic [6:0]                d0;
        logic [6:0]                d1;
        int                        exp_vel;
        int                        exp_note;
        int                        n_trig;
    } vec_t;

    int n_vectors = 0;
    int n_miscompares = 0;

    logic [31:0] m_phase;
    logic [31:0] m_inc;
    int          m_vel;
    int          exp_q[$];
    int          got_l[$];
    int          got_r[$];

    int     alu_lat = 1;
    int     stall_at_issue = -1;
    int     stall_len = 0;
    int     stall_run = 0;
    int     stall_cycles = 0;
    int     issue_cnt = 0;
    int     rdy_cnt = 0;
    int     proto_err = 0;
    int     pend_cnt = 0;
    longint pend_l;
    longint pend_r;
    logic [8:0]         held_op;
    logic signed [17:0] held_a;
    logic signed [17:0] held_b;

    function automatic logic [31:0] model_inc(input int n);
        real f;
        f = 440.0 * 2.0 ** ((51.0 + real'(n % 12)) / 12.0);
        return 32'(longint'($floor(f * 4294967296.0 / 48000.0 + 0.5))) >> (10 - n / 12);
    endfunction

    function automatic longint sat_model(input longint v);
        if (v > 131071)
            return 131071;
        if (v < -131071)
            return -131071;
        return v;
    endfunction

    function automatic int model_out(input logic [31:0] ph, input int vel);
        logic signed [17:0] xs;
        longint x, ax, b, p, y;
        xs = ph[31:14];
        x  = longint'(xs);
        ax = (x < 0) ? -x : x;
        b  = 131072 - ax;
        if (b > 131071)
            b = 131071;
        p = x * b;
        y = sat_model(p >>> 15);
`ifdef GEN_SINE_REFINE_EN
        begin
            longint ay, bref;
            ay   = (y < 0) ? -y : y;
            bref = ((ay - 131071) * 29491) >>> 17;
            p    = (y <<< 17) + y * bref;
            y    = sat_model(p >>> 17);
        end
`endif
        p = y * longint'(vel * 1024);
        return int'(p >>> 17);
    endfunction

    // ALU model plus output monitor: stalls on request, acks after alu_lat cycles.
    always @(negedge clk) begin
        if (reset) begin
            pend_cnt  = 0;
            alu_ack   = 1'b0;
            alu_stall = 1'b0;
            stall_run = 0;
        end else begin
            alu_ack = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    alu_ack = 1'b1;
                    alu_pl  = 48'(pend_l);
                    alu_pr  = 48'(pend_r);
                end
            end
            alu_stall = 1'b0;
            if (alu_strobe) begin
                if (!alu_cycle)
                    proto_err++;
                if (issue_cnt == stall_at_issue && stall_run < stall_len) begin
                    alu_stall = 1'b1;
                    if (stall_run == 0) begin
                        held_op = alu_op;
                        held_a  = alu_al;
                        held_b  = alu_bl;
                    end else if (alu_op !== held_op || alu_al !== held_a || alu_bl !== held_b) begin
                        proto_err++;
                    end
                    stall_run++;
                    stall_cycles++;
                end else begin
                    if (stall_run > 0 && (alu_op !== held_op || alu_al !== held_a || alu_bl !== held_b))
                        proto_err++;
                    stall_run = 0;
                    if (alu_al !== alu_ar || alu_bl !== alu_br || alu_cl !== alu_cr)
                        proto_err++;
`ifndef GEN_SINE_REFINE_EN
                    if (alu_cl != 48'sd0)
                        proto_err++;
`endif
                    pend_l = longint'(alu_al) * longint'(alu_bl);
                    pend_r = longint'(alu_ar) * longint'(alu_br);
                    if (alu_op == 9'h00D) begin
                        pend_l = pend_l + longint'(alu_cl);
                        pend_r = pend_r + longint'(alu_cr);
                    end else if (alu_op != 9'h001) begin
                        proto_err++;
                    end
                    pend_cnt = alu_lat;
                    issue_cnt++;
                end
            end
            if (smp_out_rdy) begin
                got_l.push_back(int'(smp_out_l));
                got_r.push_back(int'(smp_out_r));
                rdy_cnt++;
            end
        end
    end

    task automatic check_output(input string name, input longint actual, input longint expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        midi_rdy     = 1'b1;
        midi_cmd     = v.cmd;
        midi_ch_sysn = v.ch;
        midi_data0   = v.d0;
        midi_data1   = v.d1;
        @(negedge clk);
        midi_rdy = 1'b0;
    endtask

    task automatic collect(input string tag);
        int waited;
        int exp_v;
        waited = 0;
        while (got_l.size() == 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        exp_v = exp_q.pop_front();
        if (got_l.size() == 0) begin
            n_vectors++;
            n_miscompares++;
            $display("[TB] FAIL %s_timeout: no smp_out_rdy seen, expected sample %0d", tag, exp_v);
        end else begin
            check_output({tag, "_l"}, longint'(got_l.pop_front()), longint'(exp_v));
            check_output({tag, "_r"}, longint'(got_r.pop_front()), longint'(exp_v));
        end
    endtask

    task automatic run_sample(input string tag);
        int start_rdy;
        exp_q.push_back(model_out(m_phase, m_vel));
        m_phase   = m_phase + m_inc;
        start_rdy = rdy_cnt;
        @(negedge clk);
        smp_trig = 1'b1;
        @(negedge clk);
        smp_trig = 1'b0;
        collect(tag);
        repeat (3) @(negedge clk);
        check_output({tag, "_rdy_count"}, longint'(rdy_cnt - start_rdy), 1);
    endtask

    vec_t vecs[11];

    initial begin
        int start_issue;
        int start_stall;
        int start_rdy;
        int start_err;
        vec_t v;

        vecs[0]  = '{`MIDI_CMD_NOTE_ON,  4'd0, 7'h50, 7'h11,  17,  80, 3};
        vecs[1]  = '{`MIDI_CMD_NOTE_ON,  4'd1, 7'h60, 7'h21,  17,  80, 2};
        vecs[2]  = '{`MIDI_CMD_NOTE_ON,  4'd0, 7'h60, 7'h21,  33,  96, 4};
        vecs[3]  = '{`MIDI_CMD_NOTE_OFF, 4'd0, 7'h50, 7'h00,  33,  96, 2};
        vecs[4]  = '{`MIDI_CMD_NOTE_OFF, 4'd0, 7'h60, 7'h00,   0,  96, 2};
        vecs[5]  = '{`MIDI_CMD_NOTE_ON,  4'd0, 7'h7F, 7'h7F, 127, 127, 6};
        vecs[6]  = '{`MIDI_CMD_NOTE_ON,  4'd0, 7'h45, 7'h00,   0, 127, 2};
        vecs[7]  = '{`MIDI_CMD_NOTE_ON,  4'd0, 7'h00, 7'h40,  64,   0, 2};
        vecs[8]  = '{4'hB,               4'd0, 7'h07, 7'h10,  64,   0, 2};
        vecs[9]  = '{`MIDI_CMD_NOTE_ON,  4'd0, 7'h3C, 7'h7F, 127,  60, 3};
        vecs[10] = '{`MIDI_CMD_NOTE_OFF, 4'd1, 7'h3C, 7'h00, 127,  60, 2};

        reset        = 1'b1;
        midi_rdy     = 1'b0;
        midi_cmd     = '0;
        midi_ch_sysn = '0;
        midi_data0   = '0;
        midi_data1   = '0;
        smp_trig     = 1'b0;
        repeat (3) @(negedge clk);

        check_output("rst_smp_out_rdy", longint'(smp_out_rdy), 0);
        check_output("rst_smp_out_l", longint'(smp_out_l), 0);
        check_output("rst_smp_out_r", longint'(smp_out_r), 0);
        check_output("rst_alu_cycle", longint'(alu_cycle), 0);
        check_output("rst_alu_strobe", longint'(alu_strobe), 0);
        check_output("rst_alu_cl", longint'(alu_cl), 0);

        reset   = 1'b0;
        m_phase = '0;
        m_inc   = '0;
        m_vel   = 0;

        for (int i = 0; i < 11; i++) begin
            alu_lat = 1 + (i % 3);
            apply_stimulus(vecs[i]);
            m_vel = vecs[i].exp_vel;
            m_inc = model_inc(vecs[i].exp_note);
            for (int j = 0; j < vecs[i].n_trig; j++)
                run_sample($sformatf("v%0d_s%0d", i, j));
        end

        // ALU stall held for five cycles on the first multiply of a sample
        alu_lat        = 2;
        start_issue    = issue_cnt;
        start_stall    = stall_cycles;
        start_err      = proto_err;
        stall_len      = 5;
        stall_at_issue = issue_cnt;
        run_sample("stall");
        stall_at_issue = -1;
        check_output("stall_cycles", longint'(stall_cycles - start_stall), 5);
        check_output("stall_issue_count", longint'(issue_cnt - start_issue), OPS_PER_SAMPLE);
        check_output("stall_protocol", longint'(proto_err - start_err), 0);

        // second trigger while busy must be ignored
        start_rdy = rdy_cnt;
        exp_q.push_back(model_out(m_phase, m_vel));
        m_phase = m_phase + m_inc;
        @(negedge clk);
        smp_trig = 1'b1;
        @(negedge clk);
        smp_trig = 1'b0;
        @(negedge clk);
        smp_trig = 1'b1;
        @(negedge clk);
        smp_trig = 1'b0;
        collect("busy");
        repeat (20) @(negedge clk);
        check_output("busy_rdy_count", longint'(rdy_cnt - start_rdy), 1);
        check_output("busy_no_extra", longint'(got_l.size()), 0);

        // reset in the middle of a computation
        @(negedge clk);
        smp_trig = 1'b1;
        @(negedge clk);
        smp_trig = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_output("midrst_alu_cycle", longint'(alu_cycle), 0);
        check_output("midrst_alu_strobe", longint'(alu_strobe), 0);
        check_output("midrst_smp_out_l", longint'(smp_out_l), 0);
        check_output("midrst_smp_out_rdy", longint'(smp_out_rdy), 0);
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        m_phase = '0;
        m_inc   = '0;
        m_vel   = 0;
        got_l.delete();
        got_r.delete();
        v = vecs[0];
        apply_stimulus(v);
        m_vel = 17;
        m_inc = model_inc(80);
        for (int j = 0; j < 3; j++)
            run_sample($sformatf("after_rst_s%0d", j));

        check_output("protocol_errors", longint'(proto_err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
